// File: rtl/usb3_fifo_rd_ctrl.sv
// usb3_fifo_rd_ctrl: FX3 synchronous slave-FIFO read master (32-bit, wrclock domain).
// Pulls fixed-length bursts from the FX3 read socket and presents one word per
// cycle on data_out while usb_rd_state == 6, for the downstream cache write port.
// Optional feature macro: USB3_RD_TIMEOUT_EN adds a WAIT_FLAG watchdog that
// aborts to IDLE and pulses timeout_err after TIMEOUT_CYC cycles without FLAGB.
module usb3_fifo_rd_ctrl #(
  parameter int         BURST_LEN   = 256,
  parameter int         READ_LAT    = 2,
  parameter logic [1:0] RD_ADDR     = 2'b11,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic        wrclock,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        USB3_FLAGB,
  input  logic [31:0] USB3_DQ,
  output logic        USB3_SLCS_n,
  output logic        USB3_SLOE_n,
  output logic        USB3_SLRD_n,
  output logic        USB3_SLWR_n,
  output logic        USB3_PKTEND_n,
  output logic [1:0]  USB3_A,
  output logic [31:0] data_out,
  output logic [3:0]  usb_rd_state,
  output logic        burst_done,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_WAIT_FLAG = 4'd2,
    S_CS        = 4'd3,
    S_OE        = 4'd4,
    S_LEAD      = 4'd5,
    S_DATA      = 4'd6,
    S_DRAIN     = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  // Last index of the word counter in DATA and of the strobe-low counter.
  localparam logic [9:0] LAST_WORD = 10'(BURST_LEN - 1);
  // LEAD lasts READ_LAT+1 cycles so the first captured word lines up with state 6.
  localparam logic [9:0] LEAD_LAST = 10'(READ_LAT);
  localparam logic [9:0] DRAIN_LAST = 10'd1;

  // Reject parameter values the 10-bit / 16-bit counters cannot represent.
  if (BURST_LEN < 4 || BURST_LEN > 1023) begin : g_bad_burst_len
    $error("usb3_fifo_rd_ctrl: BURST_LEN out of range 4..1023");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("usb3_fifo_rd_ctrl: TIMEOUT_CYC out of range 1..65535");
  end

  state_t     state;
  logic [9:0] word_cnt;
  logic [9:0] rd_cnt;

  // The read thread is never written, so these strobes stay idle.
  assign USB3_SLWR_n   = 1'b1;
  assign USB3_PKTEND_n = 1'b1;
  assign usb_rd_state  = state;

`ifdef USB3_RD_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Burst sequencer: every bus strobe and status output is a register of this FSM.
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      rd_cnt      <= '0;
      USB3_SLCS_n <= 1'b1;
      USB3_SLOE_n <= 1'b1;
      USB3_SLRD_n <= 1'b1;
      USB3_A      <= 2'b00;
      data_out    <= '0;
      burst_done  <= 1'b0;
`ifdef USB3_RD_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      burst_done <= 1'b0;
`ifdef USB3_RD_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      // SLRD_n stays low for exactly BURST_LEN cycles, spanning LEAD and most of DATA.
      if (!USB3_SLRD_n) begin
        if (rd_cnt == LAST_WORD) begin
          USB3_SLRD_n <= 1'b1;
          rd_cnt      <= '0;
        end else begin
          rd_cnt <= rd_cnt + 10'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (rd_en) state <= S_ADDR;
        end
        S_ADDR: begin
          USB3_A <= RD_ADDR;
          state  <= S_WAIT_FLAG;
        end
        S_WAIT_FLAG: begin
          if (!rd_en) begin
            state <= S_IDLE;
`ifdef USB3_RD_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else if (USB3_FLAGB) begin
            USB3_SLCS_n <= 1'b0;
            state       <= S_CS;
`ifdef USB3_RD_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            USB3_A      <= 2'b00;
            state       <= S_IDLE;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        S_CS: begin
          USB3_SLOE_n <= 1'b0;
          state       <= S_OE;
        end
        S_OE: begin
          USB3_SLRD_n <= 1'b0;
          rd_cnt      <= '0;
          word_cnt    <= '0;
          state       <= S_LEAD;
        end
        S_LEAD: begin
          if (word_cnt == LEAD_LAST) begin
            data_out <= USB3_DQ;
            word_cnt <= '0;
            state    <= S_DATA;
          end else begin
            word_cnt <= word_cnt + 10'd1;
          end
        end
        S_DATA: begin
          if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            state    <= S_DRAIN;
          end else begin
            data_out <= USB3_DQ;
            word_cnt <= word_cnt + 10'd1;
          end
        end
        S_DRAIN: begin
          if (word_cnt == DRAIN_LAST) begin
            USB3_SLOE_n <= 1'b1;
            USB3_SLCS_n <= 1'b1;
            burst_done  <= 1'b1;
            word_cnt    <= '0;
            state       <= S_DONE;
          end else begin
            word_cnt <= word_cnt + 10'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb3_fifo_rd_ctrl.sv
// tb_usb3_fifo_rd_ctrl: directed bench for usb3_fifo_rd_ctrl with an FX3 read
// model (latency 2) feeding a scoreboard queue of expected words.
// Define USB3_RD_TIMEOUT_EN to also exercise the WAIT_FLAG watchdog.
module tb_usb3_fifo_rd_ctrl;

  localparam int BURST = 256;

  logic        wrclock;
  logic        rst_n;
  logic        rd_en;
  logic        USB3_FLAGB;
  logic [31:0] USB3_DQ;
  logic        USB3_SLCS_n;
  logic        USB3_SLOE_n;
  logic        USB3_SLRD_n;
  logic        USB3_SLWR_n;
  logic        USB3_PKTEND_n;
  logic [1:0]  USB3_A;
  logic [31:0] data_out;
  logic [3:0]  usb_rd_state;
  logic        burst_done;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int run_len = 0;
  int low_len = 0;
  int words_total = 0;
  int done_cnt = 0;
  logic [3:0] prev_state = 4'd0;

  usb3_fifo_rd_ctrl #(.BURST_LEN(BURST), .READ_LAT(2), .RD_ADDR(2'b11), .TIMEOUT_CYC(100)) dut (
    .wrclock(wrclock),
    .rst_n(rst_n),
    .rd_en(rd_en),
    .USB3_FLAGB(USB3_FLAGB),
    .USB3_DQ(USB3_DQ),
    .USB3_SLCS_n(USB3_SLCS_n),
    .USB3_SLOE_n(USB3_SLOE_n),
    .USB3_SLRD_n(USB3_SLRD_n),
    .USB3_SLWR_n(USB3_SLWR_n),
    .USB3_PKTEND_n(USB3_PKTEND_n),
    .USB3_A(USB3_A),
    .data_out(data_out),
    .usb_rd_state(usb_rd_state),
    .burst_done(burst_done),
    .timeout_err(timeout_err)
  );

  // Free-running clock, period 10.
  initial wrclock = 1'b0;
  always #5 wrclock = ~wrclock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First burst is a plain 0..255 count; later words also exercise the upper bits.
  function automatic logic [31:0] fx_word(input int n);
    logic [31:0] v;
    v = 32'(n);
    if (n < BURST) return v;
    return {~v[15:0], v[15:0]};
  endfunction

  // FX3 model: word appears on DQ two cycles after SLRD_n is seen low.
  logic [1:0]  pv = 2'b00;
  logic [31:0] pw0 = '0;
  logic [31:0] pw1 = '0;
  int          fx_cnt = 0;
  assign USB3_DQ = pv[1] ? pw1 : 32'hDEAD_BEEF;

  // Pipeline the FX3 words and record each one as an expected output.
  always @(posedge wrclock) begin
    if (!rst_n) begin
      pv <= 2'b00;
      exp_q.delete();
    end else begin
      pv[0] <= !USB3_SLRD_n;
      pw0   <= fx_word(fx_cnt);
      if (!USB3_SLRD_n) fx_cnt++;
      pv[1] <= pv[0];
      pw1   <= pw0;
      if (pv[0]) exp_q.push_back(pw0);
    end
  end

  // Monitor: scoreboard pops, burst length, strobe length and DONE framing.
  always @(negedge wrclock) begin
    logic [31:0] exp_w;
    if (!rst_n) begin
      run_len = 0;
      low_len = 0;
    end else begin
      checkOutput("state_range", 32'(usb_rd_state <= 4'd8), 32'd1);
      if (usb_rd_state == 4'd6) begin
        if (exp_q.size() == 0) begin
          checkOutput("word_expected", 32'd0, 32'd1);
        end else begin
          exp_w = exp_q.pop_front();
          checkOutput("data_word", data_out, exp_w);
        end
        checkOutput("cs_oe_in_data", {30'd0, USB3_SLCS_n, USB3_SLOE_n}, 32'd0);
        run_len++;
        words_total++;
      end else if (run_len != 0) begin
        checkOutput("burst_words", 32'(run_len), 32'(BURST));
        run_len = 0;
      end
      if (!USB3_SLRD_n) begin
        low_len++;
      end else if (low_len != 0) begin
        checkOutput("slrd_low_len", 32'(low_len), 32'(BURST));
        low_len = 0;
      end
      if (burst_done) begin
        done_cnt++;
        checkOutput("done_state", 32'(usb_rd_state), 32'd8);
        checkOutput("done_cs_release", 32'(USB3_SLCS_n), 32'd1);
      end
      if (prev_state == 4'd8) checkOutput("idle_after_done", 32'(usb_rd_state), 32'd0);
      prev_state = usb_rd_state;
    end
  end

  task automatic applyStimulus(input logic en, input logic flag);
    rd_en      = en;
    USB3_FLAGB = flag;
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget);
    for (int i = 0; i < budget && usb_rd_state !== code; i++) @(negedge wrclock);
    checkOutput("wait_state", 32'(usb_rd_state), 32'(code));
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge wrclock);
      if (burst_done === 1'b1) seen = 1'b1;
    end
    checkOutput("wait_done", 32'(seen), 32'd1);
  endtask

  // Directed sequence: reset, single burst, flag stall, rd_en drop, reset abort, back-to-back.
  initial begin
    int w0;
    int d0;
    int n;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge wrclock);

    $display("[TB] reset values");
    checkOutput("rst_strobes", {27'd0, USB3_SLCS_n, USB3_SLOE_n, USB3_SLRD_n, USB3_SLWR_n, USB3_PKTEND_n}, 32'h1F);
    checkOutput("rst_addr", 32'(USB3_A), 32'd0);
    checkOutput("rst_data", data_out, 32'd0);
    checkOutput("rst_state", 32'(usb_rd_state), 32'd0);
    checkOutput("rst_pulses", {30'd0, burst_done, timeout_err}, 32'd0);

    $display("[TB] T1 single burst");
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1);
    wait_state(4'd3, 50);
    rd_en = 1'b0;
    wait_done(400);
    repeat (10) @(negedge wrclock);
    checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t1_words", 32'(words_total), 32'(BURST));
    checkOutput("t1_last_word", data_out, 32'h0000_00FF);
    checkOutput("t1_idle", 32'(usb_rd_state), 32'd0);

    $display("[TB] T2 FLAGB stall, T3 rd_en drop mid-burst");
    applyStimulus(1'b1, 1'b0);
    repeat (50) @(negedge wrclock);
    checkOutput("t2_wait_state", 32'(usb_rd_state), 32'd2);
    checkOutput("t2_cs_idle", 32'(USB3_SLCS_n), 32'd1);
    checkOutput("t2_addr", 32'(USB3_A), 32'd3);
    checkOutput("t2_no_timeout", 32'(timeout_err), 32'd0);
    USB3_FLAGB = 1'b1;
    wait_state(4'd6, 20);
    repeat (100) @(negedge wrclock);
    rd_en = 1'b0;
    wait_done(400);
    repeat (20) @(negedge wrclock);
    checkOutput("t3_idle", 32'(usb_rd_state), 32'd0);
    checkOutput("t3_done_cnt", 32'(done_cnt), 32'd2);
    checkOutput("t3_words", 32'(words_total), 32'(2 * BURST));

    $display("[TB] T4 reset during DATA");
    rd_en = 1'b1;
    wait_state(4'd6, 50);
    repeat (40) @(negedge wrclock);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4_strobes", {29'd0, USB3_SLCS_n, USB3_SLOE_n, USB3_SLRD_n}, 32'h7);
    checkOutput("t4_state", 32'(usb_rd_state), 32'd0);
    repeat (3) @(negedge wrclock);
    w0 = words_total;
    rst_n = 1'b1;
    wait_state(4'd3, 50);
    rd_en = 1'b0;
    wait_done(400);
    repeat (5) @(negedge wrclock);
    checkOutput("t4_words", 32'(words_total - w0), 32'(BURST));
    checkOutput("t4_done_cnt", 32'(done_cnt), 32'd3);

    $display("[TB] T5 back-to-back bursts");
    w0 = words_total;
    d0 = done_cnt;
    rd_en = 1'b1;
    wait_done(400);
    wait_done(400);
    rd_en = 1'b0;
    repeat (10) @(negedge wrclock);
    checkOutput("t5_words", 32'(words_total - w0), 32'(2 * BURST));
    checkOutput("t5_done_cnt", 32'(done_cnt - d0), 32'd2);
    checkOutput("t5_idle", 32'(usb_rd_state), 32'd0);

`ifdef USB3_RD_TIMEOUT_EN
    $display("[TB] T6 WAIT_FLAG watchdog");
    applyStimulus(1'b1, 1'b0);
    wait_state(4'd2, 20);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge wrclock);
      if (usb_rd_state != 4'd2) break;
      n++;
    end
    rd_en = 1'b0;
    checkOutput("t6_wait_cycles", 32'(n), 32'd100);
    checkOutput("t6_timeout_pulse", 32'(timeout_err), 32'd1);
    checkOutput("t6_state", 32'(usb_rd_state), 32'd0);
    checkOutput("t6_addr", 32'(USB3_A), 32'd0);
    @(negedge wrclock);
    checkOutput("t6_pulse_end", 32'(timeout_err), 32'd0);
    USB3_FLAGB = 1'b1;
`else
    n = 0;
    checkOutput("no_timeout_build", 32'(timeout_err), 32'(n));
`endif

    repeat (5) @(negedge wrclock);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
